// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU command issuer.
package alu_pkg;

    localparam int DW   = 4;
    localparam int NREG = 4;
    localparam int AW   = 2;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WB    = 2'd2
    } state_t;

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Command, ALU and result signals of the issuer, bundled for port connection.
// master = the issuer; slave = the environment (command source, ALU, result sink).
interface alu_cmd_issuer_if;
    import alu_pkg::*;

    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_rd;
    logic [AW-1:0] cmd_rs;
    logic [AW-1:0] cmd_rt;
    logic          cmd_imm_en;
    logic [DW-1:0] cmd_imm;

    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [1:0]    alu_op;
    logic [DW-1:0] alu_ans;

    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_data;
    logic [AW-1:0] res_rd;
    logic          res_zero;

    modport master (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt, cmd_imm_en, cmd_imm,
        output cmd_ready,
        output alu_a, alu_b, alu_op,
        input  alu_ans,
        output res_valid, res_data, res_rd, res_zero,
        input  res_ready
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt, cmd_imm_en, cmd_imm,
        input  cmd_ready,
        input  alu_a, alu_b, alu_op,
        output alu_ans,
        input  res_valid, res_data, res_rd, res_zero,
        output res_ready
    );

endinterface

// File: rtl/alu_cmd_regfile.sv
// Small register file: async active-low clear, two combinational reads, one synchronous write.
module alu_cmd_regfile #(
    parameter int NREG = 4,
    parameter int DW   = 4,
    parameter int AW   = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_b
);

    logic [DW-1:0] regs_q [NREG];

    // Clear all entries on reset; otherwise write one entry when enabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rdata_a = regs_q[raddr_a];
    assign rdata_b = regs_q[raddr_b];

endmodule

// File: rtl/alu_cmd_issuer.sv
// Issues register-addressed commands to an external combinational ALU and
// writes the answer back to the local register file and the result port.
module alu_cmd_issuer #(
    parameter int NREG = 4,
    parameter int DW   = 4
) (
    input  logic              clk,
    input  logic              reset,
    alu_cmd_issuer_if.master  bus
);
    import alu_pkg::*;

    state_t        state_q, state_d;
    logic [DW-1:0] alu_a_q, alu_a_d;
    logic [DW-1:0] alu_b_q, alu_b_d;
    logic [1:0]    alu_op_q, alu_op_d;
    logic [AW-1:0] rd_q, rd_d;
    logic          res_valid_q, res_valid_d;
    logic [DW-1:0] res_data_q, res_data_d;
    logic [AW-1:0] res_rd_q, res_rd_d;
    logic          res_zero_q, res_zero_d;

    logic          we;
    logic [DW-1:0] rdata_a, rdata_b;

    alu_cmd_regfile #(.NREG(NREG), .DW(DW), .AW(AW)) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we      (we),
        .waddr   (rd_q),
        .wdata   (bus.alu_ans),
        .raddr_a (bus.cmd_rs),
        .rdata_a (rdata_a),
        .raddr_b (bus.cmd_rt),
        .rdata_b (rdata_b)
    );

    // Ready only in IDLE, and held low while reset is asserted.
    assign bus.cmd_ready = (state_q == S_IDLE) && reset;

    // Next-state and datapath updates: accept in IDLE, capture ALU answer in ISSUE, drain in WB.
    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        rd_d        = rd_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_rd_d    = res_rd_q;
        res_zero_d  = res_zero_q;
        we          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    alu_a_d  = rdata_a;
                    alu_b_d  = bus.cmd_imm_en ? bus.cmd_imm : rdata_b;
                    alu_op_d = bus.cmd_op;
                    rd_d     = bus.cmd_rd;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                we          = 1'b1;
                res_data_d  = bus.alu_ans;
                res_rd_d    = rd_q;
                res_zero_d  = (bus.alu_ans == '0);
                res_valid_d = 1'b1;
                state_d     = S_WB;
            end
            S_WB: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers, all returned to zero by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            rd_q        <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_rd_q    <= '0;
            res_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            rd_q        <= rd_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_rd_q    <= res_rd_d;
            res_zero_q  <= res_zero_d;
        end
    end

    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_rd    = res_rd_q;
    assign bus.res_zero  = res_zero_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with an attached combinational 4-bit ALU.
module tb_alu_cmd_issuer;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    alu_cmd_issuer_if bus();

    alu_cmd_issuer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU: mod-16 add/sub, bitwise or/and.
    always_comb begin
        case (bus.alu_op)
            2'b00:   bus.alu_ans = bus.alu_a + bus.alu_b;
            2'b01:   bus.alu_ans = bus.alu_a - bus.alu_b;
            2'b10:   bus.alu_ans = bus.alu_a | bus.alu_b;
            default: bus.alu_ans = bus.alu_a & bus.alu_b;
        endcase
    end

    typedef struct {
        logic [1:0] op, rd, rs, rt;
        logic       imm_en;
        logic [3:0] imm;
        logic [3:0] ea, eb, ed;
        logic       ez;
    } vec_t;

    vec_t vt[10];

    function automatic vec_t mk(input logic [1:0] op, rd, rs, rt, input logic imm_en,
                                input logic [3:0] imm, ea, eb, ed, input logic ez);
        vec_t v;
        v.op = op; v.rd = rd; v.rs = rs; v.rt = rt; v.imm_en = imm_en; v.imm = imm;
        v.ea = ea; v.eb = eb; v.ed = ed; v.ez = ez;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s.wait_ready: cmd_ready=%b expected 1 within 20 cycles", nm, bus.cmd_ready);
        end
    endtask

    task automatic drive_cmd(input vec_t v);
        bus.cmd_op     = v.op;
        bus.cmd_rd     = v.rd;
        bus.cmd_rs     = v.rs;
        bus.cmd_rt     = v.rt;
        bus.cmd_imm_en = v.imm_en;
        bus.cmd_imm    = v.imm;
        bus.cmd_valid  = 1'b1;
    endtask

    // Full accept / issue / writeback / drain with res_ready high.
    task automatic run_cmd(input vec_t v, input string nm);
        wait_ready(nm);
        bus.res_ready = 1'b1;
        drive_cmd(v);
        tick();
        bus.cmd_valid = 1'b0;
        chk({nm, ".alu_a"},     {4'h0, bus.alu_a},  {4'h0, v.ea});
        chk({nm, ".alu_b"},     {4'h0, bus.alu_b},  {4'h0, v.eb});
        chk({nm, ".alu_op"},    {6'h0, bus.alu_op}, {6'h0, v.op});
        chk({nm, ".issue_rdy"}, {7'h0, bus.cmd_ready}, 8'h0);
        chk({nm, ".issue_vld"}, {7'h0, bus.res_valid}, 8'h0);
        tick();
        chk({nm, ".res_valid"}, {7'h0, bus.res_valid}, 8'h1);
        chk({nm, ".res_data"},  {4'h0, bus.res_data},  {4'h0, v.ed});
        chk({nm, ".res_rd"},    {6'h0, bus.res_rd},    {6'h0, v.rd});
        chk({nm, ".res_zero"},  {7'h0, bus.res_zero},  {7'h0, v.ez});
        tick();
        chk({nm, ".drain_vld"}, {7'h0, bus.res_valid}, 8'h0);
        chk({nm, ".drain_rdy"}, {7'h0, bus.cmd_ready}, 8'h1);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_rd = 2'd0; bus.cmd_rs = 2'd0;
        bus.cmd_rt = 2'd0; bus.cmd_imm_en = 1'b0; bus.cmd_imm = 4'h0; bus.res_ready = 1'b0;

        // op rd rs rt imm_en imm | exp alu_a alu_b res_data res_zero
        vt[0] = mk(2'b00, 2'd1, 2'd0, 2'd0, 1'b1, 4'h5, 4'h0, 4'h5, 4'h5, 1'b0); // r1=5
        vt[1] = mk(2'b01, 2'd2, 2'd0, 2'd1, 1'b0, 4'h0, 4'h0, 4'h5, 4'hB, 1'b0); // r2=0-5=B
        vt[2] = mk(2'b00, 2'd1, 2'd0, 2'd0, 1'b1, 4'h9, 4'h0, 4'h9, 4'h9, 1'b0); // r1=9
        vt[3] = mk(2'b00, 2'd2, 2'd0, 2'd0, 1'b1, 4'h7, 4'h0, 4'h7, 4'h7, 1'b0); // r2=7
        vt[4] = mk(2'b00, 2'd3, 2'd1, 2'd2, 1'b0, 4'h0, 4'h9, 4'h7, 4'h0, 1'b1); // 9+7 wraps to 0
        vt[5] = mk(2'b10, 2'd0, 2'd1, 2'd0, 1'b1, 4'h6, 4'h9, 4'h6, 4'hF, 1'b0); // r0=9|6=F
        vt[6] = mk(2'b11, 2'd1, 2'd0, 2'd2, 1'b0, 4'h0, 4'hF, 4'h7, 4'h7, 1'b0); // r1=F&7=7
        vt[7] = mk(2'b01, 2'd3, 2'd2, 2'd0, 1'b1, 4'h8, 4'h7, 4'h8, 4'hF, 1'b0); // r3=7-8=F
        vt[8] = mk(2'b11, 2'd2, 2'd3, 2'd0, 1'b1, 4'h0, 4'hF, 4'h0, 4'h0, 1'b1); // r2=0
        vt[9] = mk(2'b10, 2'd3, 2'd1, 2'd2, 1'b0, 4'h0, 4'h7, 4'h0, 4'h7, 1'b0); // r3=7|0=7

        // Reset held: outputs at zero, not ready.
        tick();
        tick();
        chk("rst.cmd_ready", {7'h0, bus.cmd_ready}, 8'h0);
        chk("rst.res_valid", {7'h0, bus.res_valid}, 8'h0);
        chk("rst.alu_a",     {4'h0, bus.alu_a},     8'h0);
        chk("rst.alu_b",     {4'h0, bus.alu_b},     8'h0);
        chk("rst.alu_op",    {6'h0, bus.alu_op},    8'h0);
        chk("rst.res_data",  {4'h0, bus.res_data},  8'h0);
        chk("rst.res_rd",    {6'h0, bus.res_rd},    8'h0);
        chk("rst.res_zero",  {7'h0, bus.res_zero},  8'h0);
        reset = 1'b1;
        tick();
        chk("rel.cmd_ready", {7'h0, bus.cmd_ready}, 8'h1);

        for (int i = 0; i < 10; i++) begin
            run_cmd(vt[i], $sformatf("vec%0d", i));
        end
        // Registers now: r0=F r1=7 r2=0 r3=7

        // Back-to-back: cmd_valid held, second command reads the first's result.
        wait_ready("b2b");
        bus.res_ready = 1'b1;
        drive_cmd(mk(2'b00, 2'd0, 2'd3, 2'd0, 1'b1, 4'h1, 4'h7, 4'h1, 4'h8, 1'b0)); // r0=7+1=8
        tick();
        drive_cmd(mk(2'b01, 2'd1, 2'd0, 2'd0, 1'b1, 4'h3, 4'h8, 4'h3, 4'h5, 1'b0)); // r1=8-3=5
        chk("b2b.issue_rdy", {7'h0, bus.cmd_ready}, 8'h0);
        chk("b2b.a1",        {4'h0, bus.alu_a},     8'h7);
        tick();
        chk("b2b.wb_rdy",    {7'h0, bus.cmd_ready}, 8'h0);
        chk("b2b.res1",      {4'h0, bus.res_data},  8'h8);
        tick();
        chk("b2b.idle_rdy",  {7'h0, bus.cmd_ready}, 8'h1);
        chk("b2b.no_early",  {4'h0, bus.alu_b},     8'h1);
        tick();
        bus.cmd_valid = 1'b0;
        chk("b2b.a2",        {4'h0, bus.alu_a},     8'h8);
        chk("b2b.b2",        {4'h0, bus.alu_b},     8'h3);
        chk("b2b.op2",       {6'h0, bus.alu_op},    8'h1);
        tick();
        chk("b2b.res2",      {4'h0, bus.res_data},  8'h5);
        chk("b2b.rd2",       {6'h0, bus.res_rd},    8'h1);
        tick();
        // Registers now: r0=8 r1=5 r2=0 r3=7

        // Backpressure: result held while res_ready low; stray commands ignored.
        wait_ready("bp");
        bus.res_ready = 1'b0;
        drive_cmd(mk(2'b10, 2'd2, 2'd1, 2'd0, 1'b1, 4'h2, 4'h5, 4'h2, 4'h7, 1'b0)); // r2=5|2=7
        tick();
        drive_cmd(mk(2'b11, 2'd3, 2'd0, 2'd0, 1'b1, 4'hC, 4'h0, 4'h0, 4'h0, 1'b0));
        tick();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("bp%0d.res_valid", k), {7'h0, bus.res_valid}, 8'h1);
            chk($sformatf("bp%0d.res_data", k),  {4'h0, bus.res_data},  8'h7);
            chk($sformatf("bp%0d.res_rd", k),    {6'h0, bus.res_rd},    8'h2);
            chk($sformatf("bp%0d.cmd_ready", k), {7'h0, bus.cmd_ready}, 8'h0);
            chk($sformatf("bp%0d.alu_b", k),     {4'h0, bus.alu_b},     8'h2);
            tick();
        end
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        tick();
        chk("bp.release_vld", {7'h0, bus.res_valid}, 8'h0);
        chk("bp.release_rdy", {7'h0, bus.cmd_ready}, 8'h1);

        // Reset pulse during ISSUE: write to r1 must not land.
        wait_ready("rstiss");
        drive_cmd(mk(2'b00, 2'd1, 2'd0, 2'd0, 1'b1, 4'hF, 4'h8, 4'hF, 4'h7, 1'b0));
        tick();
        bus.cmd_valid = 1'b0;
        chk("rstiss.alu_b", {4'h0, bus.alu_b}, 8'hF);
        reset = 1'b0;
        #1;
        chk("rstiss.rdy_async", {7'h0, bus.cmd_ready}, 8'h0);
        chk("rstiss.alu_b_clr", {4'h0, bus.alu_b},     8'h0);
        tick();
        chk("rstiss.res_valid", {7'h0, bus.res_valid}, 8'h0);
        chk("rstiss.cmd_ready", {7'h0, bus.cmd_ready}, 8'h0);
        reset = 1'b1;
        tick();
        chk("rstiss.rel_rdy",   {7'h0, bus.cmd_ready}, 8'h1);
        chk("rstiss.rel_vld",   {7'h0, bus.res_valid}, 8'h0);
        run_cmd(mk(2'b10, 2'd2, 2'd1, 2'd0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1), "postrst_r1");
        run_cmd(mk(2'b00, 2'd3, 2'd0, 2'd0, 1'b1, 4'h1, 4'h0, 4'h1, 4'h1, 1'b0), "postrst_r0");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Initiator side of the 4-bit ALU interface (inA, inB, op in, ans out).
- Accepts register-addressed ALU commands over a valid/ready handshake.
- Reads operands from a local 4x4-bit register file, drives the operands and op code to the external ALU, and writes `ans` back.
- Returns each result over a second valid/ready handshake.
- Sits between a command source (testbench or simple controller) and the combinational ALU.

Parameters:
- NREG, 4, number of register-file entries (address width = 2; fixed at 4 for this revision).
- DW, 4, datapath width; matches ALU operand width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- cmd_valid  input  1  command present.
- cmd_ready  output  1  issuer can accept a command.
- cmd_op  input  2  00 add, 01 sub, 10 or, 11 and.
- cmd_rd  input  2  destination register.
- cmd_rs  input  2  source register A.
- cmd_rt  input  2  source register B.
- cmd_imm_en  input  1  1: B operand = cmd_imm instead of reg[rt].
- cmd_imm  input  4  immediate operand.
- alu_a  output  4  to ALU inA.
- alu_b  output  4  to ALU inB.
- alu_op  output  2  to ALU op.
- alu_ans  input  4  from ALU ans (combinational response).
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts result.
- res_data  output  4  result value.
- res_rd  output  2  register written.
- res_zero  output  1  res_data == 0.

Behaviour:
- Reset (reset==0, async):
  - state=IDLE; all 4 registers = 0.
  - cmd_ready=0 while reset is held; 1 in the first cycle after release.
  - alu_a/alu_b/alu_op = 0; res_valid=0, res_data=0, res_rd=0, res_zero=0.
- FSM states: IDLE, ISSUE, WB.
  - IDLE:
    - cmd_ready=1.
    - On cmd_valid&&cmd_ready at a clock edge:
      - register alu_a=reg[rs], alu_b = cmd_imm_en ? cmd_imm : reg[rt], alu_op=cmd_op;
      - latch rd;
      - next state ISSUE.
    - cmd_valid without a handshake: no change.
  - ISSUE (one cycle):
    - cmd_ready=0; alu_* stable.
    - At the edge ending ISSUE:
      - reg[rd] <= alu_ans; res_data <= alu_ans; res_rd <= rd; res_zero <= (alu_ans==0);
      - res_valid <= 1; next state WB.
  - WB:
    - res_valid=1; res_* held stable; cmd_ready=0.
    - On res_valid&&res_ready: res_valid <= 0, next state IDLE.
    - res_ready low: remain in WB indefinitely, outputs unchanged.
- Latency and throughput:
  - Handshake edge T → res_valid high after T+2.
  - Minimum issue interval 3 cycles (accept, issue, writeback/drain).
- Arithmetic is owned by the ALU and is mod 16 (add/sub wrap, no carry/borrow out). The issuer never modifies alu_ans.
- Operand read occurs at accept, so a command whose rs/rt equals the prior rd sees the updated value; no hazard is possible.
- alu_a/alu_b/alu_op hold their last values outside ISSUE; they are not cleared.
- res_ready is ignored when res_valid=0.
- Reset mid-operation (ISSUE or WB): the command is discarded, the register write does not occur if not yet completed, and all state and outputs return to reset values.
- cmd fields are sampled only on the handshake edge; changes at other times are ignored.

Decomposition:
- Shared package alu_pkg: constants OP_ADD=2'b00, OP_SUB=2'b01, OP_OR=2'b10, OP_AND=2'b11; DW=4; state encodings S_IDLE, S_ISSUE, S_WB.
- One natural sub-module, alu_cmd_regfile:
  - 4x4 registers, async active-low clear;
  - two combinational read ports;
  - one synchronous write port (we, waddr, wdata).
- The ALU itself is external; the bench connects it.

Test Plan:
- Reset, then cmd {op=00, rd=1, rs=0, imm_en=1, imm=5}, res_ready=1:
  - alu_a=0, alu_b=5, alu_op=00 during ISSUE;
  - res_valid 2 cycles after accept with res_data=5, res_rd=1, res_zero=0.
- After r1=5, cmd {op=01, rd=2, rs=0, rt=1, imm_en=0}:
  - res_data=4'hB (0-5 wrap), reg2=B.
- Load r1=9, r2=7 via imm, then {op=00, rd=3, rs=1, rt=2}:
  - res_data=0, res_zero=1.
- Back-to-back: cmd_valid held high with a different command ready:
  - cmd_ready is low during ISSUE/WB;
  - second accept no earlier than 3 cycles after the first;
  - second command reads the first's result.
- Backpressure: res_ready=0 for 4 cycles in WB:
  - res_valid/res_data/res_rd stable;
  - cmd_ready=0;
  - after res_ready=1 the state returns to IDLE next cycle.
- Reset pulse during ISSUE of {rd=1, imm=F}:
  - res_valid=0 and cmd_ready=0 while reset is held;
  - cmd_ready=1 after release;
  - subsequent {op=10, rd=2, rs=1, imm_en=1, imm=0} returns 0 (reg1 was cleared, not written).
